fifo_1: RTL and testbench

Dual-clock FIFO carrying DSIZE-bit words from the write clock domain (wclk) to the read clock domain (rclk). It uses Gray-coded pointers, two-flop pointer synchronizers and registered, pessimistic full/empty flags. It is the standard clock-domain-crossing buffer between independent producer and consumer blocks.

---
 rtl/fifo_1_pkg.sv | 16 +
 rtl/fifo_1_if.sv | 32 +++
 rtl/fifo_1_sync.sv | 30 +++
 rtl/fifo_1.sv | 120 ++++++++++++
 tb/tb_fifo_1.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_1_pkg.sv
// fifo_1_pkg -- shared definitions for the fifo_1 dual-clock FIFO.
//   DSIZE_DEF : default data word width (8)
//   ASIZE_DEF : default address width, depth = 2**ASIZE_DEF (16)
//   bin2gray  : binary to reflected Gray code conversion (up to 32 bits;
//               callers truncate to their pointer width)
`timescale 1ns/100ps
package fifo_1_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_1_if.sv
// fifo_1_if -- producer/consumer handshake bundle of the fifo_1 FIFO.
//   winc/wdata/wfull : write side, wclk domain
//   rinc/rdata/rempty: read side, rclk domain
//   wovf/runf        : sticky error flags, present only when
//                      FIFO_1_ERR_FLAGS_EN is defined
// Modports: master = the producer/consumer driving requests,
//           slave  = the FIFO itself.
`timescale 1ns/100ps
interface fifo_1_if import fifo_1_pkg::*; #(
  parameter int DSIZE = DSIZE_DEF
) ();

  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
`ifdef FIFO_1_ERR_FLAGS_EN
  logic             wovf;
  logic             runf;
`endif

`ifdef FIFO_1_ERR_FLAGS_EN
  modport master (output winc, wdata, rinc, input wfull, rdata, rempty, wovf, runf);
  modport slave  (input winc, wdata, rinc, output wfull, rdata, rempty, wovf, runf);
`else
  modport master (output winc, wdata, rinc, input wfull, rdata, rempty);
  modport slave  (input winc, wdata, rinc, output wfull, rdata, rempty);
`endif

endinterface

// File: rtl/fifo_1_sync.sv
// fifo_1_sync -- two-flop synchronizer for a Gray-coded FIFO pointer.
//   clk   : destination-domain clock
//   rst_n : destination-domain reset, synchronous, active-low
//   d     : Gray pointer from the source domain
//   q     : pointer after two destination-domain flops
// Only one bit of a Gray pointer changes per step, so a metastable first
// stage resolves to either the old or the new pointer, never a mix.
`timescale 1ns/100ps
module fifo_1_sync #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_1.sv
// fifo_1 -- dual-clock FIFO, DSIZE-bit words from wclk to rclk.
//   wclk, wrst_n : write clock, synchronous active-low write reset
//   rclk, rrst_n : read clock, synchronous active-low read reset
//   bus (slave)  : winc/wdata/wfull in wclk, rinc/rdata/rempty in rclk;
//                  rdata is first-word fall-through, valid while !rempty
// Optional: define FIFO_1_ERR_FLAGS_EN to add sticky wovf (write while
// full, wclk domain) and runf (read while empty, rclk domain) on the bus.
// Pointers are ASIZE+1 bits; the extra MSB distinguishes full from empty
// when the address bits are equal. Flags are computed from the next
// pointer and registered, so they assert on the edge that fills/empties.
`timescale 1ns/100ps
module fifo_1 import fifo_1_pkg::*; #(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input logic     wclk,
  input logic     wrst_n,
  input logic     rclk,
  input logic     rrst_n,
  fifo_1_if.slave bus
);

  localparam int PW    = ASIZE + 1;
  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wbin, wptr, wbinnext, wgraynext, wq2_rptr;
  logic          wfull_q, wfull_val, wen;

  assign wen       = bus.winc & ~wfull_q;
  assign wbinnext  = wbin + PW'(wen);
  assign wgraynext = PW'(bin2gray(32'(wbinnext)));
  // Full when the write pointer is one lap ahead of the read pointer: in
  // Gray code that means the two MSBs differ and the rest match.
  assign wfull_val = (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin    <= '0;
      wptr    <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin    <= wbinnext;
      wptr    <= wgraynext;
      wfull_q <= wfull_val;
    end
  end

  // Storage is not reset; pointers alone define which words are live.
  always_ff @(posedge wclk) begin
    if (wrst_n && wen)
      mem[wbin[ASIZE-1:0]] <= bus.wdata;
  end

  assign bus.wfull = wfull_q;

  // ---------------- read domain ----------------
  logic [PW-1:0] rbin, rptr, rbinnext, rgraynext, rq2_wptr;
  logic          rempty_q, rempty_val, ren;

  assign ren        = bus.rinc & ~rempty_q;
  assign rbinnext   = rbin + PW'(ren);
  assign rgraynext  = PW'(bin2gray(32'(rbinnext)));
  assign rempty_val = (rgraynext == rq2_wptr);

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin     <= rbinnext;
      rptr     <= rgraynext;
      rempty_q <= rempty_val;
    end
  end

  assign bus.rdata  = mem[rbin[ASIZE-1:0]];
  assign bus.rempty = rempty_q;

  // ---------------- pointer crossings ----------------
  fifo_1_sync #(.W(PW)) u_sync_r2w (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr),
    .q     (wq2_rptr)
  );

  fifo_1_sync #(.W(PW)) u_sync_w2r (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr),
    .q     (rq2_wptr)
  );

`ifdef FIFO_1_ERR_FLAGS_EN
  // ---------------- sticky error flags ----------------
  logic wovf_q, runf_q;

  always_ff @(posedge wclk) begin
    if (!wrst_n)
      wovf_q <= 1'b0;
    else if (bus.winc && wfull_q)
      wovf_q <= 1'b1;
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n)
      runf_q <= 1'b0;
    else if (bus.rinc && rempty_q)
      runf_q <= 1'b1;
  end

  assign bus.wovf = wovf_q;
  assign bus.runf = runf_q;
`endif

endmodule

// File: tb/tb_fifo_1.sv
// tb_fifo_1 -- self-checking bench for fifo_1 (wclk 10 ns, rclk 12 ns).
// A word queue models the FIFO contents; a single compare process checks
// rdata/rempty/wfull against it half a nanosecond after every clock edge.
// Directed phases add hand-computed literal expectations.
`timescale 1ns/100ps
module tb_fifo_1;

  logic wclk, rclk, wrst_n, rrst_n;

  fifo_1_if #(.DSIZE(8)) bus ();

  fifo_1 #(.DSIZE(8), .ASIZE(4)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  initial begin
    rclk = 1'b0;
    forever #6 rclk = ~rclk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model: words in flight ----------------
  logic [7:0] model_q[$];

  always @(posedge wclk) begin
    if (!wrst_n)
      model_q.delete();
    else if (bus.winc && !bus.wfull)
      model_q.push_back(bus.wdata);
  end

  always @(posedge rclk) begin
    if (!rrst_n)
      model_q.delete();
    else if (bus.rinc && !bus.rempty && model_q.size() > 0)
      void'(model_q.pop_front());
  end

  // Clock edges sit on integer ns and never coincide, so +0.5 ns is
  // always clear of the next edge of either clock.
  always @(posedge wclk or posedge rclk) begin
    #0.5;
    if (wrst_n && rrst_n) begin
      check("model_depth_le16", 32'(model_q.size() <= 16), 32'd1);
      if (!bus.rempty) begin
        check("model_not_underflow", 32'(model_q.size() > 0), 32'd1);
        if (model_q.size() > 0)
          check("model_rdata", 32'(bus.rdata), 32'(model_q[0]));
      end
      if (model_q.size() >= 16)
        check("model_full_flag", 32'(bus.wfull), 32'd1);
    end
  end

  // ---------------- directed stimulus ----------------
  int wgot, rgot, budget, lat;

  initial begin
    bus.winc  = 1'b0;
    bus.wdata = 8'h00;
    bus.rinc  = 1'b0;
    wrst_n    = 1'b0;
    rrst_n    = 1'b0;

    // Reset: first wclk edge at 5 ns, first rclk edge at 6 ns.
    #11;
    check("reset_wfull", 32'(bus.wfull), 32'd0);
    check("reset_rempty", 32'(bus.rempty), 32'd1);
    #1;
    wrst_n = 1'b1;
    rrst_n = 1'b1;

    // Fill: 19 write attempts, only the first 16 land.
    for (int i = 0; i < 19; i++) begin
      @(negedge wclk);
      bus.winc  = 1'b1;
      bus.wdata = 8'(i);
      if (i == 15) check("fill_wfull_before_16th", 32'(bus.wfull), 32'd0);
      @(posedge wclk);
      #1;
      if (i == 15) check("fill_wfull_on_16th", 32'(bus.wfull), 32'd1);
    end
    @(negedge wclk);
    bus.winc = 1'b0;

    // Drain: 0x00..0x0F in order, then empty.
    @(negedge rclk);
    bus.rinc = 1'b1;
    fork
      begin
        @(posedge rclk);
        repeat (3) @(posedge wclk);
        #1;
        check("drain_wfull_fall_3edges", 32'(bus.wfull), 32'd0);
      end
    join_none
    for (int i = 0; i < 16; i++) begin
      check("drain_rdata", 32'(bus.rdata), 32'(i));
      check("drain_rempty_low", 32'(bus.rempty), 32'd0);
      @(posedge rclk);
      #1;
    end
    check("drain_rempty_after16", 32'(bus.rempty), 32'd1);

    // Empty read: rinc stays high for several edges while empty.
    repeat (4) @(posedge rclk);
    #1;
    check("empty_read_rempty", 32'(bus.rempty), 32'd1);
`ifdef FIFO_1_ERR_FLAGS_EN
    check("err_wovf_set", 32'(bus.wovf), 32'd1);
    check("err_runf_set", 32'(bus.runf), 32'd1);
`endif
    @(negedge rclk);
    bus.rinc = 1'b0;
    @(negedge wclk);
    bus.winc  = 1'b1;
    bus.wdata = 8'h3C;
    @(negedge wclk);
    bus.winc = 1'b0;
    budget = 0;
    while (bus.rempty && budget < 10) begin
      @(posedge rclk);
      #1;
      budget++;
    end
    check("after_empty_read_rempty", 32'(bus.rempty), 32'd0);
    check("after_empty_read_rdata", 32'(bus.rdata), 32'h3C);
    @(negedge rclk);
    bus.rinc = 1'b1;
    @(negedge rclk);
    bus.rinc = 1'b0;
    #1;
    check("after_single_read_rempty", 32'(bus.rempty), 32'd1);

    // Wrap-around: 40 words streamed with both requests held high.
    wgot = 0;
    rgot = 0;
    fork
      begin
        budget = 0;
        while (wgot < 40 && budget < 1000) begin
          @(negedge wclk);
          bus.winc  = 1'b1;
          bus.wdata = 8'(8'h40 + wgot);
          if (!bus.wfull) wgot++;
          budget++;
        end
        @(negedge wclk);
        bus.winc = 1'b0;
      end
      begin
        int rb;
        rb = 0;
        @(negedge rclk);
        bus.rinc = 1'b1;
        while (rgot < 40 && rb < 1000) begin
          if (!bus.rempty) begin
            check("wrap_rdata", 32'(bus.rdata), 32'(8'h40 + rgot));
            rgot++;
          end
          @(negedge rclk);
          rb++;
        end
        bus.rinc = 1'b0;
      end
    join
    check("wrap_written", 32'(wgot), 32'd40);
    check("wrap_read", 32'(rgot), 32'd40);
    #1;
    check("wrap_rempty_end", 32'(bus.rempty), 32'd1);

    // Mid-operation reset with 8 words queued.
    for (int k = 0; k < 8; k++) begin
      @(negedge wclk);
      bus.winc  = 1'b1;
      bus.wdata = 8'(8'h80 + k);
    end
    @(negedge wclk);
    bus.winc = 1'b0;
    repeat (5) @(posedge rclk);
    #1;
    check("queued_rempty", 32'(bus.rempty), 32'd0);
    check("queued_head", 32'(bus.rdata), 32'h80);
    @(negedge wclk);
    #1;
    wrst_n = 1'b0;
    rrst_n = 1'b0;
    #33;
    wrst_n = 1'b1;
    rrst_n = 1'b1;
    check("midreset_rempty", 32'(bus.rempty), 32'd1);
    check("midreset_wfull", 32'(bus.wfull), 32'd0);
`ifdef FIFO_1_ERR_FLAGS_EN
    check("midreset_wovf", 32'(bus.wovf), 32'd0);
    check("midreset_runf", 32'(bus.runf), 32'd0);
`endif
    @(negedge wclk);
    bus.winc  = 1'b1;
    bus.wdata = 8'hA5;
    @(posedge wclk);
    #1;
    bus.winc = 1'b0;
    lat = 0;
    while (bus.rempty && lat < 10) begin
      @(posedge rclk);
      #1;
      lat++;
    end
    check("a5_latency_2to3", 32'(lat >= 2 && lat <= 3), 32'd1);
    check("a5_rdata", 32'(bus.rdata), 32'hA5);
    @(negedge rclk);
    bus.rinc = 1'b1;
    @(negedge rclk);
    bus.rinc = 1'b0;
    #1;
    check("a5_drained_rempty", 32'(bus.rempty), 32'd1);

    repeat (4) @(posedge wclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
